rotary_quadrature_filter: RTL and testbench

//  Upstream conditioning stage for the rotary-encoder MMIO block.
//  - Synchronises and debounces the raw 2-bit quadrature pins.
//  - Decodes the Gray sequence into one-cycle step events plus a direction bit.
//  - Its rotary_event/rotary_right outputs drive the MMIO event/interrupt logic directly.

---
 rtl/rotary_quadrature_filter.sv | 108 ++++++++++
 tb/tb_rotary_quadrature_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_quadrature_filter.sv
// rtl/rotary_quadrature_filter.sv - quadrature pin sync, per-channel debounce and step decode
// Optional position counter enabled by defining ROTARY_POSITION_EN.
module rotary_quadrature_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EVENT_MODE      = 0
`ifdef ROTARY_POSITION_EN
  ,
  parameter int POS_WIDTH       = 8
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] rotary_in,
  output logic       rotary_event,
  output logic       rotary_right,
  output logic       rotary_error,
  output logic [1:0] rotary_state
`ifdef ROTARY_POSITION_EN
  ,
  output logic [POS_WIDTH-1:0] position
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]        sync1, sync2, cur, prev;
  logic [CW-1:0]     cnt [2];
  logic signed [2:0] net;
  logic signed [3:0] net_step;
  logic [1:0]        delta;
  logic              is_single, is_double, step_right, event_next;

  assign rotary_state = cur;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      cur   <= 2'b00;
      cnt   <= '{default: '0};
    end else begin
      sync1 <= rotary_in;
      sync2 <= sync1;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2[ch] == cur[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == CNT_LAST) begin
          cur[ch] <= sync2[ch];
          cnt[ch] <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + 1'b1;
        end
      end
    end
  end

  // net counts signed single steps since the last visit to 00; a full detent arrives with +/-4
  always_comb begin
    delta     = prev ^ cur;
    is_double = (delta == 2'b11);
    is_single = (delta == 2'b01) || (delta == 2'b10);
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_right = 1'b1;
      default:                            step_right = 1'b0;
    endcase
    net_step = $signed({net[2], net}) + (step_right ? 4'sd1 : -4'sd1);
    if (EVENT_MODE != 0) begin
      event_next = is_single;
    end else begin
      event_next = is_single && (cur == 2'b00) && ((net_step == 4'sd4) || (net_step == -4'sd4));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= 2'b00;
      net          <= 3'sd0;
      rotary_event <= 1'b0;
      rotary_error <= 1'b0;
      rotary_right <= 1'b0;
    end else begin
      prev         <= cur;
      rotary_event <= event_next;
      rotary_error <= is_double;
      if (event_next) begin
        rotary_right <= step_right;
      end
      // an illegal jump invalidates the excursion; it can no longer sum to a full detent
      if (cur == 2'b00 || is_double) begin
        net <= 3'sd0;
      end else if (is_single) begin
        net <= net_step[2:0];
      end
    end
  end

`ifdef ROTARY_POSITION_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      position <= '0;
    end else if (event_next) begin
      position <= step_right ? position + 1'b1 : position - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rotary_quadrature_filter.sv
// tb/tb_rotary_quadrature_filter.sv - scoreboard bench, EVENT_MODE 0 and 1 instances on shared pins
module tb_rotary_quadrature_filter;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] pins;
  logic       ev0, rt0, er0, ev1, rt1, er1;
  logic [1:0] st0, st1;
`ifdef ROTARY_POSITION_EN
  logic [7:0] pos0, pos1;
`else
  wire  [7:0] pos0 = 8'h00;
  wire  [7:0] pos1 = 8'h00;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rotary_quadrature_filter #(.DEBOUNCE_CYCLES(DEB), .EVENT_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .rotary_in(pins),
    .rotary_event(ev0), .rotary_right(rt0), .rotary_error(er0), .rotary_state(st0)
`ifdef ROTARY_POSITION_EN
    , .position(pos0)
`endif
  );

  rotary_quadrature_filter #(.DEBOUNCE_CYCLES(DEB), .EVENT_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .rotary_in(pins),
    .rotary_event(ev1), .rotary_right(rt1), .rotary_error(er1), .rotary_state(st1)
`ifdef ROTARY_POSITION_EN
    , .position(pos1)
`endif
  );

  typedef struct {
    bit         err;
    bit         right;
    int         cyc;
    logic [7:0] pos;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  bit         mright[2];
  logic [7:0] mpos[2];
  logic [1:0] mprev;
  int         exc_sum;
  bit         exc_bad;
  // position of each {B,A} state along the clockwise cycle, and its inverse
  int         seq_pos[4]   = '{0, 1, 3, 2};
  int         seq_state[4] = '{0, 1, 3, 2};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic predict(input int m, input logic [1:0] p, input logic [1:0] n, input int c);
    exp_t e;
    int   d;
    bit   fire;
    bit   dir;
    if (p == n) return;
    d      = (seq_pos[n] - seq_pos[p] + 4) % 4;
    e.cyc  = c + 3 + DEB;
    e.err  = (d == 2);
    e.right = 1'b0;
    e.pos  = 8'h00;
    fire   = 1'b0;
    dir    = (d == 1);
    if (m == 0) begin
      if (d == 2) exc_bad = 1'b1;
      else exc_sum += (d == 1) ? 1 : -1;
      if (n == 2'b00) begin
        fire    = !e.err && !exc_bad && (exc_sum == 4 || exc_sum == -4);
        dir     = (exc_sum > 0);
        exc_sum = 0;
        exc_bad = 1'b0;
      end
    end else begin
      fire = !e.err;
    end
    if (fire) begin
      mright[m] = dir;
      mpos[m]   = dir ? mpos[m] + 8'd1 : mpos[m] - 8'd1;
      e.right   = dir;
      e.pos     = mpos[m];
    end
    if (e.err || fire) begin
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic mon(input int m, input logic ev, input logic er, input logic rt, input logic [7:0] ps);
    exp_t e;
    int   sz;
    sz = (m == 0) ? q0.size() : q1.size();
    while (sz > 0) begin
      if (m == 0) e = q0[0];
      else e = q1[0];
      if (e.cyc >= cyc) break;
      if (m == 0) e = q0.pop_front();
      else e = q1.pop_front();
      tests++;
      fails++;
      $display("FAIL m%0d_missing_pulse: expected err=%0d at cycle %0d, pulse absent", m, e.err, e.cyc);
      sz--;
    end
    if (ev || er) begin
      if (sz == 0) begin
        check($sformatf("m%0d_spurious_pulse", m), {30'd0, ev, er}, 32'd0);
      end else begin
        if (m == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check($sformatf("m%0d_pulse_kind", m), {30'd0, ev, er}, e.err ? 32'd1 : 32'd2);
        check($sformatf("m%0d_pulse_cycle", m), cyc, e.cyc);
        if (!e.err) begin
          check($sformatf("m%0d_right", m), {31'd0, rt}, {31'd0, e.right});
`ifdef ROTARY_POSITION_EN
          check($sformatf("m%0d_position", m), {24'd0, ps}, {24'd0, e.pos});
`endif
        end
      end
    end
  endtask

  always @(posedge clock) begin
    #1;
    mon(0, ev0, er0, rt0, pos0);
    mon(1, ev1, er1, rt1, pos1);
  end

  task automatic chk_zero(input string tag);
    check({tag, "_m0_outputs"}, {27'd0, ev0, er0, rt0, st0}, 32'd0);
    check({tag, "_m1_outputs"}, {27'd0, ev1, er1, rt1, st1}, 32'd0);
`ifdef ROTARY_POSITION_EN
    check({tag, "_positions"}, {16'd0, pos0, pos1}, 32'd0);
`endif
  endtask

  task automatic chk_hold(input string tag);
    check({tag, "_m0_state"}, {30'd0, st0}, {30'd0, mprev});
    check({tag, "_m1_state"}, {30'd0, st1}, {30'd0, mprev});
    check({tag, "_m0_right_held"}, {31'd0, rt0}, {31'd0, mright[0]});
    check({tag, "_m1_right_held"}, {31'd0, rt1}, {31'd0, mright[1]});
  endtask

  task automatic step(input logic [1:0] n, input int hold);
    predict(0, mprev, n, cyc);
    predict(1, mprev, n, cyc);
    pins  = n;
    mprev = n;
    repeat (hold) @(negedge clock);
    chk_hold("step");
  endtask

  // pulse shorter than the debounce window must never reach the decoder
  task automatic glitch(input int ch, input int len);
    pins = mprev ^ (2'b01 << ch);
    repeat (len) @(negedge clock);
    pins = mprev;
    repeat (DEB + 3) @(negedge clock);
    chk_hold("glitch");
  endtask

  task automatic do_reset(input logic [1:0] r);
    reset_n = 1'b0;
    #1;
    chk_zero("reset_assert");
    q0.delete();
    q1.delete();
    mright  = '{1'b0, 1'b0};
    mpos    = '{8'h00, 8'h00};
    mprev   = 2'b00;
    exc_sum = 0;
    exc_bad = 1'b0;
    repeat (3) begin
      @(negedge clock);
      pins = 2'($urandom_range(0, 3));
    end
    @(negedge clock);
    chk_zero("reset_held");
    pins    = r;
    reset_n = 1'b1;
    predict(0, 2'b00, r, cyc);
    predict(1, 2'b00, r, cyc);
    mprev = r;
    repeat (DEB + 6) @(negedge clock);
    chk_hold("reset_release");
  endtask

  initial begin
    int dir;
    int k;
    logic [1:0] n;
    reset_n = 1'b0;
    pins    = 2'b00;
    mprev   = 2'b00;
    mright  = '{1'b0, 1'b0};
    mpos    = '{8'h00, 8'h00};
    exc_sum = 0;
    exc_bad = 1'b0;
    repeat (4) begin
      @(negedge clock);
      pins = 2'($urandom_range(0, 3));
      #1;
      chk_zero("in_reset");
    end
    @(negedge clock);
    pins = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk_hold("after_release");

    // right detent, then three left detents
    step(2'b01, 12); step(2'b11, 12); step(2'b10, 12); step(2'b00, 12);
    repeat (3) begin
      step(2'b10, 12); step(2'b11, 12); step(2'b01, 12); step(2'b00, 12);
    end

    // bounce on A, then a real hold
    repeat (5) glitch(0, 3);
    step(2'b01, 12);
    step(2'b00, 12);

    // illegal jumps and a reversal
    step(2'b11, 12); step(2'b00, 12);
    step(2'b01, 12); step(2'b00, 12);
    step(2'b01, 12); step(2'b11, 12); step(2'b01, 12); step(2'b00, 12);

    // reset mid-rotation with pins left at 11
    step(2'b01, 12);
    do_reset(2'b11);

    dir = 1;
    for (int i = 0; i < 240; i++) begin
      if (i % 60 == 59) begin
        do_reset(2'($urandom_range(0, 3)));
      end else begin
        k = $urandom_range(0, 19);
        if (k >= 19) begin
          glitch($urandom_range(0, 1), $urandom_range(1, DEB - 1));
        end else begin
          if (k >= 14 && k < 17) dir = -dir;
          if (k >= 17) n = mprev ^ 2'b11;
          else n = 2'(seq_state[(seq_pos[mprev] + dir + 4) % 4]);
          step(n, DEB + 3 + $urandom_range(0, 5));
        end
      end
    end

    repeat (DEB + 6) @(negedge clock);
    check("m0_queue_drained", q0.size(), 32'd0);
    check("m1_queue_drained", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
